// File: rtl/axil_cfg_sequencer.sv
// Buffers (register index, data) commands in a small FIFO and plays each one out
// as a single AXI-Lite write, one outstanding at a time, counting completions and errors.
module axil_cfg_sequencer #(
    parameter int FIFO_DEPTH         = 4,
    parameter int C_S_AXI_DATA_WIDTH = 64,
    parameter int C_S_AXI_ADDR_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [3:0]                        cmd_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     cmd_data,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
    output logic [2:0]                        s_axil_awprot,
    output logic                              s_axil_awvalid,
    input  logic                              s_axil_awready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axil_wdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
    output logic                              s_axil_wvalid,
    input  logic                              s_axil_wready,
    input  logic [1:0]                        s_axil_bresp,
    input  logic                              s_axil_bvalid,
    output logic                              s_axil_bready,
    output logic                              busy,
    output logic [15:0]                       done_count,
    output logic [7:0]                        err_count
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 4 + DW;

    typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

    state_t            state_q, state_d;
    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [PW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              full, empty, push, pop;
    logic [EW-1:0]     head;

    logic              launch_q, launch_d;
    logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [AW-1:0]     awaddr_q, awaddr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [15:0]       done_count_q, done_count_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              aw_hs, w_hs, both_done, b_hs;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state_q == IDLE) && !empty;
    assign head      = mem_q[rd_ptr_q[PW-1:0]];

    assign aw_hs     = awvalid_q && s_axil_awready;
    assign w_hs      = wvalid_q && s_axil_wready;
    assign both_done = (aw_done_q || aw_hs) && (w_done_q || w_hs);
    assign b_hs      = s_axil_bvalid && bready_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PW-1:0]] <= {cmd_addr, cmd_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop) state_d = SEND;
            SEND:    if (both_done) state_d = RESP;
            RESP:    if (b_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The popped entry is latched one cycle before the valids rise (launch_q).
    always_comb begin
        launch_d     = pop;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        done_count_d = done_count_q;
        err_count_d  = err_count_q;
        if (pop) begin
            awaddr_d  = {{(AW-7){1'b0}}, head[EW-1 -: 4], 3'b000};
            wdata_d   = head[DW-1:0];
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end
        if (launch_q) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
        end
        if (aw_hs) begin
            awvalid_d = 1'b0;
            aw_done_d = 1'b1;
        end
        if (w_hs) begin
            wvalid_d = 1'b0;
            w_done_d = 1'b1;
        end
        if (state_q == SEND && both_done) bready_d = 1'b1;
        if (state_q == RESP && b_hs) begin
            bready_d     = 1'b0;
            done_count_d = done_count_q + 16'd1;
            if (s_axil_bresp != 2'b00 && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            launch_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            done_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            launch_q     <= launch_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            done_count_q <= done_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign s_axil_awaddr  = awaddr_q;
    assign s_axil_awprot  = 3'b000;
    assign s_axil_awvalid = awvalid_q;
    assign s_axil_wdata   = wdata_q;
    assign s_axil_wstrb   = '1;
    assign s_axil_wvalid  = wvalid_q;
    assign s_axil_bready  = bready_q;
    assign busy           = (state_q != IDLE) || !empty;
    assign done_count     = done_count_q;
    assign err_count      = err_count_q;

endmodule
